// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and key index constants for the keypad event block
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned KEY_UP    = 2;
    localparam int unsigned KEY_RIGHT = 5;
    localparam int unsigned KEY_DOWN  = 6;
    localparam int unsigned KEY_LEFT  = 7;
    localparam int unsigned KEY_OK    = 10;
    localparam int unsigned KEY_NUM   = 11;
    localparam int unsigned KEY_EXIT  = 12;
    localparam int unsigned KEY_BACK  = 13;
    localparam int unsigned KEY_NEXT  = 14;
    localparam int unsigned KEY_INFO  = 15;

    localparam logic [15:0] REP_MASK_DEFAULT = 16'h00E4;

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key: 2-FF sync, debounce FSM, optional hold-to-repeat
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned REP_DELAY  = 50000000,
    parameter int unsigned REP_PERIOD = 15000000,
    parameter int unsigned CNT_W      = 26,
    parameter bit          REPEAT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press,
    output logic press_next,
    output logic release_pulse,
    output logic held,
    output logic repeat_flag
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REP_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic             sync1_q, s_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, rc_q, rc_d;
    logic [CNT_W-1:0] cnt_inc, rc_inc, rep_limit;
    logic             first_q, first_d;
    logic             press_q, press_d, release_q, release_d;
    logic             held_q, held_d, flag_q, flag_d;

    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign rc_inc    = (rc_q == CNT_MAX) ? rc_q : rc_q + CNT_ONE;
    // first_q selects the initial delay until the first repeat has fired
    assign rep_limit = first_q ? DELAY_LAST : PER_LAST;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rc_d      = rc_q;
        first_d   = first_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held_q;
        flag_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    rc_d    = '0;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (!s_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT) begin
                    if (rc_q == rep_limit) begin
                        press_d = 1'b1;
                        flag_d  = 1'b1;
                        rc_d    = '0;
                        first_d = 1'b0;
                    end else begin
                        rc_d = rc_inc;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                // rc holds its value here; a bounce back restarts the repeat delay
                if (s_q) begin
                    state_d = ST_HELD;
                    rc_d    = '0;
                    first_d = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rc_q      <= '0;
            first_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            sync1_q   <= key_raw;
            s_q       <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rc_q      <= rc_d;
            first_q   <= first_d;
            press_q   <= press_d;
            release_q <= release_d;
            held_q    <= held_d;
            flag_q    <= flag_d;
        end
    end

    assign press         = press_q;
    assign press_next    = press_d & rst;
    assign release_pulse = release_q;
    assign held          = held_q;
    assign repeat_flag   = flag_q;

endmodule

// File: rtl/key_event.sv
// rtl/key_event.sv - keypad event top: per-key debounce cells, priority encoder, held OR
module key_event
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS            = 16,
    parameter int unsigned DEB_CYCLES        = 500000,
    parameter int unsigned REP_DELAY         = 50000000,
    parameter int unsigned REP_PERIOD        = 15000000,
    parameter logic [N_KEYS-1:0] REP_MASK    = REP_MASK_DEFAULT,
    parameter int unsigned CNT_W             = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] held,
    output logic [N_KEYS-1:0] repeat_flag,
    output logic              key_valid,
    output logic [3:0]        key_code,
    output logic              any_held
);

    logic [N_KEYS-1:0] press_next;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        key_code_q, key_code_d;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD),
            .CNT_W      (CNT_W),
            .REPEAT     (REP_MASK[i])
        ) u_cell (
            .clk           (clk),
            .rst           (rst),
            .key_raw       (key_raw[i]),
            .press         (press[i]),
            .press_next    (press_next[i]),
            .release_pulse (release_pulse[i]),
            .held          (held[i]),
            .repeat_flag   (repeat_flag[i])
        );
    end

    // Encode from the cells' next-state press so code/valid line up with press
    always_comb begin
        key_valid_d = |press_next;
        key_code_d  = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (press_next[i]) key_code_d = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign any_held  = |held;

endmodule

// File: tb/tb_key_event.sv
// tb/tb_key_event.sv - randomized and directed bench for key_event against a run-length model
module tb_key_event;
    import key_pkg::*;

    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int HOLD = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] key_raw = '0;
    logic [15:0] press, release_pulse, held, repeat_flag;
    logic        key_valid, any_held;
    logic [3:0]  key_code;
    logic [69:0] dut_vec;

    key_event #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_raw       (key_raw),
        .press         (press),
        .release_pulse (release_pulse),
        .held          (held),
        .repeat_flag   (repeat_flag),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .any_held      (any_held)
    );

    always #5 clk = ~clk;

    assign dut_vec = {press, release_pulse, held, repeat_flag, key_valid, key_code, any_held};

    // Model: a level is accepted after DEB consecutive disagreeing synced samples;
    // repeats fire when the time spent pressed reaches RD, RD+RP, RD+2RP, ...
    logic [15:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_press = '0, m_rel = '0, m_flag = '0;
    logic [15:0] rep_mask = REP_MASK_DEFAULT;
    int          m_run[16], m_age[16], m_next[16];
    int          n_checks = 0, n_pass = 0;

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] r = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [69:0] exp_vec();
        return {m_press, m_rel, m_deb, m_flag, |m_press, lowest(m_press), |m_deb};
    endfunction

    task automatic model_step(input logic rst_v, input logic [15:0] raw);
        logic s;
        m_press = '0; m_rel = '0; m_flag = '0;
        if (!rst_v) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int i = 0; i < 16; i++) begin m_run[i] = 0; m_age[i] = 0; m_next[i] = RD; end
            return;
        end
        for (int i = 0; i < 16; i++) begin
            s = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
            if (s != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = s;
                    m_run[i] = 0;
                    if (s) begin m_press[i] = 1'b1; m_age[i] = 0; m_next[i] = RD; end
                    else m_rel[i] = 1'b1;
                end
            end else begin
                if (m_deb[i] && m_run[i] > 0) begin
                    m_age[i] = 0; m_next[i] = RD;
                end else if (m_deb[i] && rep_mask[i]) begin
                    m_age[i]++;
                    if (m_age[i] == m_next[i]) begin
                        m_press[i] = 1'b1; m_flag[i] = 1'b1; m_next[i] += RP;
                    end
                end
                m_run[i] = 0;
            end
        end
    endtask

    task automatic tick();
        logic        rst_v = rst;
        logic [15:0] raw = key_raw;
        @(posedge clk);
        model_step(rst_v, raw);
        #1;
    endtask

    task automatic settle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        key_raw = 16'hFFFF;
        tick(); tick();
        n_checks++;
        if (dut_vec !== 70'd0) $display("FAIL reset_state: got %h want 0", dut_vec);
        else n_pass++;
        key_raw = '0;
        rst = 1'b1;
        settle(3);
    endtask

    task automatic test_clean_press();
        int t_press = -1, t_rel = -1, n_press = 0;
        logic [3:0] code_at = '0;
        logic valid_at = 1'b0;
        key_raw[KEY_OK] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL clean_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (press[KEY_OK]) begin
                n_press++;
                if (t_press < 0) begin t_press = c; code_at = key_code; valid_at = key_valid; end
            end
        end
        n_checks++;
        if (t_press != DEB + 2 || n_press != 1) $display("FAIL clean_press_time: got %0d (%0d pulses) want %0d (1)", t_press, n_press, DEB + 2);
        else n_pass++;
        n_checks++;
        if (code_at !== 4'(KEY_OK) || valid_at !== 1'b1) $display("FAIL clean_code: got %0d/%b want %0d/1", code_at, valid_at, KEY_OK);
        else n_pass++;
        key_raw[KEY_OK] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL clean_rel_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (release_pulse[KEY_OK] && t_rel < 0) t_rel = c;
        end
        n_checks++;
        if (t_rel != DEB + 2 || held[KEY_OK] !== 1'b0) $display("FAIL clean_release_time: got %0d held %b want %0d held 0", t_rel, held[KEY_OK], DEB + 2);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int n_evt = 0;
        for (int c = 0; c < 27; c++) begin
            key_raw[KEY_NEXT] = (c < 3) || (c >= 4 && c < 7);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL bounce_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (press[KEY_NEXT] || held[KEY_NEXT] || release_pulse[KEY_NEXT]) n_evt++;
        end
        n_checks++;
        if (n_evt != 0) $display("FAIL bounce_events: got %0d want 0", n_evt);
        else n_pass++;
    endtask

    task automatic test_repeat(input int key, input bit rep);
        int times[$];
        int nflag = 0, exp_n = 1;
        key_raw[key] = 1'b1;
        for (int c = 1; c <= HOLD + DEB + 8; c++) begin
            if (c == HOLD + 1) key_raw[key] = 1'b0;
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL repeat_model k%0d c%0d: got %h want %h", key, c, dut_vec, exp_vec());
            else n_pass++;
            if (press[key]) begin
                times.push_back(c);
                if (repeat_flag[key]) nflag++;
            end
        end
        if (rep) for (int t = DEB + 2 + RD; t <= HOLD + 2; t += RP) exp_n++;
        n_checks++;
        if (times.size() != exp_n || nflag != exp_n - 1) $display("FAIL repeat_count k%0d: got %0d/%0d flags want %0d/%0d", key, times.size(), nflag, exp_n, exp_n - 1);
        else n_pass++;
        n_checks++;
        if (times.size() == 0 || times[0] != DEB + 2) $display("FAIL repeat_first k%0d: got %0d want %0d", key, (times.size() > 0) ? times[0] : -1, DEB + 2);
        else n_pass++;
        if (rep) begin
            n_checks++;
            if (times.size() < 3 || times[1] != DEB + 2 + RD || times[2] != DEB + 2 + RD + RP)
                $display("FAIL repeat_spacing k%0d: got %0d,%0d want %0d,%0d", key,
                         (times.size() > 1) ? times[1] : -1, (times.size() > 2) ? times[2] : -1, DEB + 2 + RD, DEB + 2 + RD + RP);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        key_raw[KEY_RIGHT] = 1'b1;
        key_raw[KEY_LEFT]  = 1'b1;
        settle(DEB + 2);
        n_checks++;
        if (press !== 16'h00A0 || key_valid !== 1'b1 || key_code !== 4'd5)
            $display("FAIL simultaneous: got %h/%b/%0d want 00a0/1/5", press, key_valid, key_code);
        else n_pass++;
        key_raw = '0;
        settle(DEB + 4);
    endtask

    task automatic test_reset_mid();
        int t_press = -1;
        key_raw[KEY_DOWN] = 1'b1;
        settle(4);
        rst = 1'b0;
        tick();
        n_checks++;
        if (dut_vec !== 70'd0) $display("FAIL reset_mid_clear: got %h want 0", dut_vec);
        else n_pass++;
        rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL reset_mid_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (press[KEY_DOWN] && t_press < 0) t_press = c;
        end
        n_checks++;
        if (t_press != DEB + 2) $display("FAIL reset_mid_press: got %0d want %0d", t_press, DEB + 2);
        else n_pass++;
        key_raw = '0;
        settle(DEB + 4);
    endtask

    task automatic test_release_bounce();
        int t_rep = -1, n_bad = 0;
        key_raw[KEY_UP] = 1'b1;
        settle(10);
        key_raw[KEY_UP] = 1'b0;
        settle(2);
        key_raw[KEY_UP] = 1'b1;
        for (int c = 1; c <= RD + 6; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL relbounce_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (!held[KEY_UP] || release_pulse[KEY_UP]) n_bad++;
            if (press[KEY_UP] && t_rep < 0) t_rep = c;
        end
        n_checks++;
        if (n_bad != 0 || t_rep != 3 + RD) $display("FAIL relbounce_repeat: got %0d (bad %0d) want %0d (bad 0)", t_rep, n_bad, 3 + RD);
        else n_pass++;
        key_raw = '0;
        settle(DEB + 4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3, 0) == 0) key_raw[$urandom_range(15, 0)] ^= 1'b1;
            rst = ($urandom_range(399, 0) != 0);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
        end
        rst = 1'b1;
        key_raw = '0;
        settle(DEB + 4);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat(KEY_UP, 1'b1);
        test_repeat(KEY_EXIT, 1'b0);
        test_simultaneous();
        test_reset_mid();
        test_release_bounce();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Sits between the matrix keypad scanner and the game/menu control logic.
- Takes the scanner's 16 raw key levels, which are asynchronous to clk and bouncy, and turns them into clean clk-domain events.
- Per key, it synchronises, debounces, and emits single-cycle press/release pulses plus a held level.
- Direction keys get hold-to-repeat.
- Also provides a priority-encoded key code for consumers that handle one key at a time.

Parameters:
- N_KEYS, 16, number of keys (fixed layout, index = scanner btn index)
- DEB_CYCLES, 500000, consecutive stable clk cycles required to accept a level change (5 ms at 100 MHz)
- REP_DELAY, 50000000, cycles from the press pulse to the first repeat pulse
- REP_PERIOD, 15000000, cycles between subsequent repeat pulses
- REP_MASK, 16'h00E4, keys with auto-repeat (bits 2, 5, 6, 7 = up, right, down, left)
- CNT_W, 26, counter width; must hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- key_raw  in  N_KEYS  raw key levels from scanner, 1 = pressed, asynchronous
- press  out  N_KEYS  1-cycle pulse per accepted press or repeat
- release  out  N_KEYS  1-cycle pulse per accepted release
- held  out  N_KEYS  1 while key is debounced-pressed
- repeat_flag  out  N_KEYS  1-cycle, set together with press only for repeat pulses
- key_valid  out  1  1-cycle, any press bit set this cycle
- key_code  out  4  index of lowest-numbered set press bit, valid with key_valid
- any_held  out  1  OR of held

Behaviour:
- Reset: all outputs 0, all key FSMs IDLE, all counters 0, sync flops 0. Takes effect on any clk edge with rst=0; aborts in-progress debounce/repeat with no pulses.
- Synchroniser: 2-FF per bit; s[i] = second stage.
- Per-key FSM (states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), one counter each.
- IDLE:
  - s=1 -> PRESS_WAIT, cnt=1.
- PRESS_WAIT:
  - s=0 -> IDLE (bounce rejected, no output).
  - s=1 with cnt==DEB_CYCLES-1 -> HELD; press=1 next cycle; held=1 from that same cycle.
  - otherwise cnt++.
- Press latency: key_raw rises before edge k and stays high -> press high during cycle k+DEB_CYCLES+2. Shorter high glitches produce nothing.
- HELD:
  - s=0 -> RELEASE_WAIT, cnt=1; held stays 1.
  - Repeat keys (REP_MASK[i]=1) use a separate repeat counter rc, cleared at the press pulse.
  - First repeat when rc reaches REP_DELAY; then every REP_PERIOD.
  - Each repeat asserts press and repeat_flag for 1 cycle.
  - Non-repeat keys never repeat.
- RELEASE_WAIT:
  - s=1 -> HELD; rc cleared, so the repeat schedule restarts with REP_DELAY; no new press pulse.
  - s=0 with cnt==DEB_CYCLES-1 -> IDLE; release=1 next cycle; held=0 same cycle.
  - otherwise cnt++.
  - rc is frozen during RELEASE_WAIT.
- Counters saturate; never wrap.
- Multiple keys:
  - Each key is independent; several press bits may be set in one cycle.
  - key_valid=|press; key_code = lowest set index; others still visible on press.
- key_valid/key_code are registered in the same cycle as press (no extra latency); key_code=0 when key_valid=0.
- Press and release of the same key can never coincide.

Decomposition:
- Shared package key_pkg:
  - key FSM state encoding (2-bit enum)
  - key index constants: KEY_UP=2, KEY_RIGHT=5, KEY_DOWN=6, KEY_LEFT=7, KEY_OK=10, KEY_NUM=11, KEY_EXIT=12, KEY_BACK=13, KEY_NEXT=14, KEY_INFO=15
  - default REP_MASK
- One sub-module key_debounce_cell, single key (sync, FSM, counters, repeat), instantiated N_KEYS times via generate with parameter REPEAT = REP_MASK[i].
- key_event top contains the cells plus the priority encoder and OR reductions.

Test Plan (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8):
- Clean press: key_raw[10] rises before edge 10, held high.
  - press[10], key_valid=1, key_code=10 in cycle 16 only; held[10]=1 from cycle 16.
  - Drop key_raw -> release[10] pulse 6 cycles after the drop.
- Bounce: key_raw[14] high 3 cycles, low 1, high 3, then low.
  - No press, no held, no release ever.
- Repeat: key_raw[2] held 60 cycles.
  - press pulses at t0 (repeat_flag=0), t0+20, t0+28, t0+36, ... (repeat_flag=1).
  - Same hold on key 12 gives only the t0 pulse.
- Simultaneous: key_raw[5] and key_raw[7] rise on the same edge.
  - press=16'h00A0, key_valid=1, key_code=5 in one cycle.
- Reset mid-operation: rst=0 for 1 cycle while key 6 is in PRESS_WAIT at cnt=2.
  - All outputs 0 afterwards.
  - Key still held -> full DEB_CYCLES re-debounce, press[6] at rst release +DEB_CYCLES+2.
- Release bounce: during RELEASE_WAIT of key 2, key_raw returns high after 2 cycles.
  - held stays 1; no release, no extra press.
  - Next repeat comes 20 cycles after re-entering HELD.
